rr_stream_mux: RTL

Parametrised N:1 stream multiplexer with valid/ready handshakes, round-robin or fixed-priority arbitration, and a registered output stage. Successor to the fixed 16-bit 4:1 combinational select. Used where several pipeline producers share one consumer, for example writeback sources or memory requestors, and selection must be fair and tolerate consumer stalls.

---
 rtl/rr_stream_mux_pkg.sv | 11 +
 rtl/rr_stream_mux_arbiter.sv | 65 ++++++
 rtl/rr_stream_mux.sv | 79 +++++++
 3 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

    localparam int DEFAULT_W = 16;

    // Channel index width; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr upward, or fixed priority from index 0.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int RR   = 1,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    localparam logic [SELW:0] N_L = (SELW + 1)'(N);

    logic [SELW-1:0] base;
    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    rot;
    logic [SELW-1:0] off;
    logic            found;
    logic [SELW:0]   sum;

    assign base    = (RR != 0) ? ptr : '0;
    assign req_dbl = {req, req};
    assign any     = |req;

    // Rotating the doubled vector by base puts the search start at bit 0.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req_dbl[int'(base) + i];
        end
    end

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                off   = SELW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= N_L) begin
            sum = sum - N_L;
        end
        gnt_idx = sum[SELW-1:0];
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            if (any && (gnt_idx == SELW'(i))) begin
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 stream multiplexer with round-robin or fixed-priority arbitration and a registered output.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int W    = DEFAULT_W,
    parameter int N    = 4,
    parameter int RR   = 1,
    parameter int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_sel
);

    // Handshake: a word moves across a port only in a cycle where its valid and
    // ready are both high; a source holds valid/data stable until that happens,
    // and ready may depend combinationally on valid but never the reverse.

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic            load;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] gnt_idx;
    logic            any;
    logic [SELW-1:0] ptr;
    logic [W-1:0]    sel_word;

    rr_arbiter #(
        .N    (N),
        .RR   (RR),
        .SELW (SELW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load     = rst_n && (!out_valid || out_ready);
    assign in_ready = load ? gnt : '0;

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_word = sel_word | in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any) begin
                out_data  <= sel_word;
                out_sel   <= gnt_idx;
                out_valid <= 1'b1;
                // Wrap at N-1 rather than at the index width's natural limit.
                if ((RR != 0) && (N > 1)) begin
                    ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
